seq_ctrl: RTL and testbench

- Multi-cycle sequencer for the Y86-64 SEQ datapath. Walks one instruction through fetch, decode, execute, memory, write-back and PC-update.
- Asserts one stage enable per cycle; owns the architectural PC and the status (stat) register.
- Provides run / single-step / halt control, a memory-stage ready handshake with a timeout, and cycle / retired-instruction counters.
- Sits between the top-level processor wrapper and the six stage blocks, replacing the free-running PC update on every clk edge.

---
 rtl/seq_pkg.sv | 47 ++++
 rtl/seq_perf_ctr.sv | 26 ++
 rtl/seq_ctrl.sv | 142 ++++++++++++++
 tb/tb_seq_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the Y86-64 SEQ sequencer:
// status codes, FSM state encoding and instruction codes.
package seq_pkg;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_DECODE  = 3'd2;
  localparam logic [2:0] ST_EXECUTE = 3'd3;
  localparam logic [2:0] ST_MEMORY  = 3'd4;
  localparam logic [2:0] ST_WB      = 3'd5;
  localparam logic [2:0] ST_PCUPD   = 3'd6;
  localparam logic [2:0] ST_STOPPED = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_FETCH     = ST_FETCH,
    S_DECODE    = ST_DECODE,
    S_EXECUTE   = ST_EXECUTE,
    S_MEMORY    = ST_MEMORY,
    S_WRITEBACK = ST_WB,
    S_PCUPD     = ST_PCUPD,
    S_STOPPED   = ST_STOPPED
  } state_t;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  function automatic logic is_busy(state_t s);
    return !(s == S_IDLE || s == S_STOPPED);
  endfunction

endpackage

// File: rtl/seq_perf_ctr.sv
// Wrapping cycle and retired-instruction counters
// for the SEQ sequencer.
module seq_perf_ctr #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             busy,
  input  logic             retire,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (busy)
        cycle_cnt <= cycle_cnt + 1'b1;
      if (retire)
        instr_cnt <= instr_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_ctrl.sv
// Multi-cycle SEQ sequencer: one stage strobe per cycle,
// owns PC and stat, run/step control, memory timeout.
module seq_ctrl
  import seq_pkg::*;
#(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int          MEM_TIMEOUT = 16,
  parameter int          CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic [63:0]      updated_pc,
  input  logic             hlt,
  input  logic             instr_valid,
  input  logic             imem_error,
  input  logic             dmem_error,
  input  logic             mem_ready,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             execute_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic             pc_en,
  output logic [63:0]      pc,
  output logic [2:0]       stat,
  output logic             busy,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        mode_cont, mode_nxt;
  logic [63:0] pc_nxt;
  logic [2:0]  stat_nxt;
  logic [7:0]  wait_cnt, wait_nxt;
  logic        retire;
  logic [5:0]  en_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      mode_cont <= 1'b0;
      pc        <= RESET_PC;
      stat      <= STAT_AOK;
      wait_cnt  <= '0;
      en_q      <= '0;
    end else begin
      state     <= state_nxt;
      mode_cont <= mode_nxt;
      pc        <= pc_nxt;
      stat      <= stat_nxt;
      wait_cnt  <= wait_nxt;
      en_q      <= {state_nxt == S_PCUPD,
                    state_nxt == S_WRITEBACK,
                    state_nxt == S_MEMORY,
                    state_nxt == S_EXECUTE,
                    state_nxt == S_DECODE,
                    state_nxt == S_FETCH};
    end
  end

  always_comb begin
    state_nxt = state;
    mode_nxt  = mode_cont;
    pc_nxt    = pc;
    stat_nxt  = stat;
    wait_nxt  = '0;
    retire    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (run) begin
          state_nxt = S_FETCH;
          mode_nxt  = 1'b1;
        end else if (step) begin
          state_nxt = S_FETCH;
          mode_nxt  = 1'b0;
        end
      end
      S_FETCH: begin
        // faults leave pc pointing at the offending instruction
        if (imem_error) begin
          state_nxt = S_STOPPED;
          stat_nxt  = STAT_ADR;
        end else if (!instr_valid) begin
          state_nxt = S_STOPPED;
          stat_nxt  = STAT_INS;
        end else if (hlt) begin
          state_nxt = S_STOPPED;
          stat_nxt  = STAT_HLT;
          retire    = 1'b1;
        end else begin
          state_nxt = S_DECODE;
        end
      end
      S_DECODE:  state_nxt = S_EXECUTE;
      S_EXECUTE: state_nxt = S_MEMORY;
      S_MEMORY: begin
        if (dmem_error) begin
          state_nxt = S_STOPPED;
          stat_nxt  = STAT_ADR;
        end else if (mem_ready) begin
          state_nxt = S_WRITEBACK;
        end else if (wait_cnt == TMO_LAST) begin
          state_nxt = S_STOPPED;
          stat_nxt  = STAT_ADR;
        end else begin
          wait_nxt = wait_cnt + 8'd1;
        end
      end
      S_WRITEBACK: state_nxt = S_PCUPD;
      S_PCUPD: begin
        pc_nxt    = updated_pc;
        retire    = 1'b1;
        state_nxt = (mode_cont && run) ? S_FETCH : S_IDLE;
      end
      S_STOPPED: state_nxt = S_STOPPED;
      default:   state_nxt = S_IDLE;
    endcase
  end

  assign fetch_en   = en_q[0];
  assign decode_en  = en_q[1];
  assign execute_en = en_q[2];
  assign mem_en     = en_q[3];
  assign wb_en      = en_q[4];
  assign pc_en      = en_q[5];
  assign busy       = is_busy(state);

  seq_perf_ctr #(.CNT_W(CNT_W)) u_perf (
    .clk       (clk),
    .rst       (rst),
    .busy      (busy),
    .retire    (retire),
    .cycle_cnt (cycle_cnt),
    .instr_cnt (instr_cnt)
  );

endmodule

// File: tb/tb_seq_ctrl.sv
// Scoreboard bench for seq_ctrl: random instruction streams
// against a per-instruction outcome model.
module tb_seq_ctrl;

  localparam int          T   = 4;
  localparam logic [63:0] RPC = 64'h40;
  localparam int          CW  = 8;

  localparam int K_NORM = 0;
  localparam int K_HLT  = 1;
  localparam int K_INS  = 2;
  localparam int K_ADRF = 3;
  localparam int K_DMEM = 4;
  localparam int K_TMO  = 5;

  typedef struct {
    logic [63:0] pc;
    logic [2:0]  stat;
    int          icnt;
    int          ccnt;
    int          cyc;
    int          mem;
    int          wbp;
  } exp_t;

  logic clk = 1'b0;
  logic rst, run, step, hlt, instr_valid;
  logic imem_error, dmem_error, mem_ready;
  logic [63:0] updated_pc, pc;
  logic fetch_en, decode_en, execute_en;
  logic mem_en, wb_en, pc_en, busy;
  logic [2:0] stat;
  logic [CW-1:0] cycle_cnt, instr_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t sb[$];

  logic [63:0] m_pc;
  logic [2:0]  m_stat;
  int          m_icnt, m_ccnt;
  bit          idle_bad = 1'b0;

  seq_ctrl #(
    .RESET_PC(RPC), .MEM_TIMEOUT(T), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .step(step),
    .updated_pc(updated_pc), .hlt(hlt),
    .instr_valid(instr_valid), .imem_error(imem_error),
    .dmem_error(dmem_error), .mem_ready(mem_ready),
    .fetch_en(fetch_en), .decode_en(decode_en),
    .execute_en(execute_en), .mem_en(mem_en),
    .wb_en(wb_en), .pc_en(pc_en), .pc(pc), .stat(stat),
    .busy(busy), .cycle_cnt(cycle_cnt),
    .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Outcome of one instruction from the architectural rules.
  task automatic model(input int kind, input int w,
                       input logic [63:0] upc, output exp_t e);
    e.mem = 0;
    e.wbp = 0;
    case (kind)
      K_NORM: begin
        e.cyc = 5 + w + 1; e.mem = w + 1; e.wbp = 2;
        m_pc = upc; m_icnt++; m_stat = 3'd1;
      end
      K_HLT:  begin e.cyc = 1; m_icnt++; m_stat = 3'd2; end
      K_INS:  begin e.cyc = 1; m_stat = 3'd4; end
      K_ADRF: begin e.cyc = 1; m_stat = 3'd3; end
      K_DMEM: begin
        e.cyc = 3 + w + 1; e.mem = w + 1; m_stat = 3'd3;
      end
      default: begin
        e.cyc = 3 + T; e.mem = T; m_stat = 3'd3;
      end
    endcase
    m_icnt = m_icnt % (1 << CW);
    m_ccnt = (m_ccnt + e.cyc) % (1 << CW);
    e.pc   = m_pc;
    e.stat = m_stat;
    e.icnt = m_icnt;
    e.ccnt = m_ccnt;
  endtask

  // Monitor: one scoreboard entry per finished instruction.
  initial begin : monitor
    bit   prev_busy, ord_bad;
    int   a_cyc, a_mem, a_wbp, last, idx;
    logic [5:0] s;
    exp_t e;
    prev_busy = 0; ord_bad = 0;
    a_cyc = 0; a_mem = 0; a_wbp = 0; last = 0;
    forever begin
      @(posedge clk);
      #1;
      s = {pc_en, wb_en, mem_en, execute_en, decode_en, fetch_en};
      if (rst) begin
        sb.delete();
        prev_busy = 0; ord_bad = 0;
        a_cyc = 0; a_mem = 0; a_wbp = 0;
      end else begin
        if (prev_busy && (!busy || fetch_en)) begin
          if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_instr: got %0d cycles want none",
                     a_cyc);
          end else begin
            e = sb.pop_front();
            chk("pc", pc, e.pc);
            chk("stat", 64'(stat), 64'(e.stat));
            chk("instr_cnt", 64'(instr_cnt), 64'(e.icnt));
            chk("cycle_cnt", 64'(cycle_cnt), 64'(e.ccnt));
            chk("instr_cycles", 64'(a_cyc), 64'(e.cyc));
            chk("mem_cycles", 64'(a_mem), 64'(e.mem));
            chk("wb_pc_strobes", 64'(a_wbp), 64'(e.wbp));
            chk("strobe_order", 64'(ord_bad), 64'd0);
          end
          a_cyc = 0; a_mem = 0; a_wbp = 0; ord_bad = 0;
        end
        if (busy) begin
          idx = 0;
          for (int i = 0; i < 6; i++)
            if (s[i]) idx = i;
          if ($countones(s) != 1)
            ord_bad = 1;
          else if (a_cyc == 0 && idx != 0)
            ord_bad = 1;
          else if (a_cyc != 0 && idx != last + 1 &&
                   !(idx == 3 && last == 3))
            ord_bad = 1;
          last = idx;
          a_cyc++;
          a_mem += int'(mem_en);
          a_wbp += int'(wb_en) + int'(pc_en);
        end else if (s != 6'd0) begin
          idle_bad = 1;
        end
        prev_busy = busy;
      end
    end
  end

  task automatic do_instr(input int kind, input int w,
                          input logic [63:0] upc,
                          input bit drop_run, input bit step_dec);
    exp_t e;
    bit got, done;
    int k;
    model(kind, w, upc, e);
    sb.push_back(e);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = fetch_en;
    end
    if (!got) begin
      chk("fetch_start_timeout", 64'd0, 64'd1);
      return;
    end
    step        = 0;
    hlt         = (kind == K_HLT);
    instr_valid = !(kind == K_INS || kind == K_ADRF);
    imem_error  = (kind == K_ADRF) ? 1'b1 : 1'($urandom_range(0, 1) & (kind == K_HLT ? 0 : 0));
    updated_pc  = upc;
    mem_ready   = 0;
    dmem_error  = 0;
    if (drop_run) run = 0;
    k = 0;
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      step = 0;
      hlt = 0; instr_valid = 1; imem_error = 0;
      if (decode_en && step_dec) step = 1;
      if (mem_en) begin
        case (kind)
          K_NORM: mem_ready = (k >= w);
          K_DMEM: mem_ready = (k == w) && ($urandom_range(0, 1) == 1);
          default: mem_ready = 0;
        endcase
        dmem_error = (kind == K_DMEM) && (k == w);
        k++;
      end else begin
        mem_ready = 0;
        dmem_error = 0;
      end
      if (pc_en || !busy) done = 1;
    end
    if (!done) chk("instr_end_timeout", 64'd0, 64'd1);
    mem_ready = 0;
    dmem_error = 0;
  endtask

  task automatic do_reset();
    run = 0; step = 0;
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pc", pc, RPC);
    chk("rst_stat", 64'(stat), 64'd1);
    chk("rst_strobes", 64'({fetch_en, decode_en, execute_en,
                            mem_en, wb_en, pc_en}), 64'd0);
    chk("rst_cycle_cnt", 64'(cycle_cnt), 64'd0);
    chk("rst_instr_cnt", 64'(instr_cnt), 64'd0);
    rst = 0;
    m_pc = RPC; m_stat = 3'd1; m_icnt = 0; m_ccnt = 0;
  endtask

  task automatic hold_check(input string nm);
    repeat (5) @(negedge clk);
    chk({nm, "_busy"}, 64'(busy), 64'd0);
    chk({nm, "_stat"}, 64'(stat), 64'(m_stat));
    chk({nm, "_pc"}, pc, m_pc);
    chk({nm, "_cycle_cnt"}, 64'(cycle_cnt), 64'(m_ccnt));
  endtask

  task automatic step_start();
    @(negedge clk);
    step = 1;
  endtask

  initial begin : stim
    int n, endk;
    run = 0; step = 0; hlt = 0; instr_valid = 1;
    imem_error = 0; dmem_error = 0; mem_ready = 0;
    updated_pc = '0;
    do_reset();

    // continuous run, halt on the third fetch
    run = 1;
    do_instr(K_NORM, 0, 64'h0A, 0, 0);
    do_instr(K_NORM, 0, 64'h1234, 0, 0);
    do_instr(K_HLT, 0, 64'h9999, 0, 0);
    hold_check("halted");
    chk("halt_instr_cnt", 64'(instr_cnt), 64'd3);
    do_reset();

    // single step, ignored step in decode, then memory wait
    step_start();
    do_instr(K_NORM, 0, 64'h14, 0, 1);
    hold_check("step_idle");
    step_start();
    do_instr(K_NORM, 3, 64'h28, 0, 0);
    hold_check("step_wait");
    run = 1;
    do_instr(K_NORM, 1, 64'h30, 0, 0);
    do_instr(K_INS, 0, 64'h0, 0, 0);
    hold_check("ins");
    do_reset();

    // imem_error wins over an illegal opcode
    run = 1;
    do_instr(K_ADRF, 0, 64'h0, 0, 0);
    hold_check("adr_fetch");
    do_reset();

    // memory timeout
    run = 1;
    do_instr(K_NORM, 2, 64'h50, 0, 0);
    do_instr(K_TMO, 0, 64'h60, 0, 0);
    hold_check("timeout");
    do_reset();

    // reset while waiting in MEMORY
    step_start();
    @(negedge clk);
    step = 0;
    for (int i = 0; i < 10 && !mem_en; i++) @(negedge clk);
    chk("mem_reached", 64'(mem_en), 64'd1);
    @(negedge clk);
    do_reset();

    for (int r = 0; r < 6; r++) begin
      run = 1;
      n = $urandom_range(30, 45);
      for (int i = 0; i < n; i++)
        do_instr(K_NORM, $urandom_range(0, T - 1),
                 {$urandom, $urandom}, 0, 0);
      endk = $urandom_range(0, 5);
      if (endk == 0) begin
        do_instr(K_NORM, $urandom_range(0, T - 1),
                 {$urandom, $urandom}, 1, 0);
        hold_check("run_drop");
        step_start();
        do_instr(K_NORM, $urandom_range(0, T - 1),
                 {$urandom, $urandom}, 0, 1);
        hold_check("rand_step");
      end else begin
        do_instr(endk, $urandom_range(0, T - 1),
                 {$urandom, $urandom}, 0, 0);
        hold_check("rand_fault");
      end
      do_reset();
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("idle_strobes", 64'(idle_bad), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
